// File: rtl/mult_unpack_seq.sv
// FP32 multiplier front end: unpacks and classifies two operands, forms the 24x24
// mantissa product with an iterative shift-add loop and the biased exponent sum.
module mult_unpack_seq #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [47:0] result_p,
    output logic [9:0]  exp_sum,
    output logic        sign,
    output logic        zero_f,
    output logic        inf_f,
    output logic        nan_f,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int N = 24 / RADIX_BITS;
    localparam logic [4:0] LAST_CNT = 5'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Operand unpack and classification
    // ------------------------------------------------------------------
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic [7:0]  ea_adj, eb_adj;
    logic [23:0] sig_a, sig_b;
    logic [9:0]  exp_raw;
    logic        nan_in, inf_in, zero_in, special_in;

    always_comb begin
        ea = a[30:23];
        ma = a[22:0];
        eb = b[30:23];
        mb = b[22:0];

        a_zero = (ea == 8'h00) && (ma == 23'd0);
        a_inf  = (ea == 8'hFF) && (ma == 23'd0);
        a_nan  = (ea == 8'hFF) && (ma != 23'd0);
        b_zero = (eb == 8'h00) && (mb == 23'd0);
        b_inf  = (eb == 8'hFF) && (mb == 23'd0);
        b_nan  = (eb == 8'hFF) && (mb != 23'd0);

        // Denormals carry no hidden bit but share the exponent of the smallest normal.
        ea_adj = (ea == 8'h00) ? 8'd1 : ea;
        eb_adj = (eb == 8'h00) ? 8'd1 : eb;
        sig_a  = {(ea != 8'h00), ma};
        sig_b  = {(eb != 8'h00), mb};

        exp_raw = {2'b00, ea_adj} + {2'b00, eb_adj} - 10'd127;

        nan_in     = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
        inf_in     = (a_inf | b_inf) & ~nan_in;
        zero_in    = (a_zero | b_zero) & ~nan_in;
        special_in = nan_in | inf_in | zero_in;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [23:0] mcand_q,     mcand_d;
    logic [23:0] mplier_q,    mplier_d;
    logic [47:0] acc_q,       acc_d;
    logic [47:0] result_p_q,  result_p_d;
    logic [9:0]  exp_sum_q,   exp_sum_d;
    logic        sign_q,      sign_d;
    logic        zero_q,      zero_d;
    logic        inf_q,       inf_d;
    logic        nan_q,       nan_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic [47:0] pp;
    logic [5:0]  shamt;

    always_comb begin
        shamt = 6'(cnt_q * RADIX_BITS);
        pp    = (48'(mcand_q) * 48'(mplier_q[RADIX_BITS-1:0])) << shamt;
    end

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        result_p_d = result_p_q;
        exp_sum_d  = exp_sum_q;
        sign_d     = sign_q;
        zero_d     = zero_q;
        inf_d      = inf_q;
        nan_d      = nan_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d     = a[31] ^ b[31];
                    nan_d      = nan_in;
                    inf_d      = inf_in;
                    zero_d     = zero_in;
                    exp_sum_d  = special_in ? 10'd0 : exp_raw;
                    acc_d      = '0;
                    result_p_d = '0;
                    mplier_d   = sig_b;
                    // Specials make a single pass with a zero multiplicand so they
                    // reach DONE one edge later with an all-zero product.
                    mcand_d    = special_in ? 24'd0 : sig_a;
                    cnt_d      = special_in ? LAST_CNT : 5'd0;
                    state_d    = MUL;
                end
            end
            MUL: begin
                acc_d    = acc_q + pp;
                mplier_d = mplier_q >> RADIX_BITS;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    result_p_d = acc_d;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_p_q  <= '0;
            exp_sum_q   <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_p_q  <= result_p_d;
            exp_sum_q   <= exp_sum_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            inf_q       <= inf_d;
            nan_q       <= nan_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result_p  = result_p_q;
    assign exp_sum   = exp_sum_q;
    assign sign      = sign_q;
    assign zero_f    = zero_q;
    assign inf_f     = inf_q;
    assign nan_f     = nan_q;

endmodule

// File: tb/tb_mult_unpack_seq.sv
// Directed-vector bench for mult_unpack_seq: default radix-1 instance plus a
// radix-4 instance for the shortened-latency case.
module tb_mult_unpack_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        in_valid, in_ready;
    logic [47:0] result_p;
    logic [9:0]  exp_sum;
    logic        sign, zero_f, inf_f, nan_f, out_valid, out_ready;

    logic        in_valid4, in_ready4;
    logic [47:0] result_p4;
    logic [9:0]  exp_sum4;
    logic        sign4, zero4, inf4, nan4, out_valid4, out_ready4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_unpack_seq #(.RADIX_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_p(result_p), .exp_sum(exp_sum), .sign(sign),
        .zero_f(zero_f), .inf_f(inf_f), .nan_f(nan_f),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mult_unpack_seq #(.RADIX_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .result_p(result_p4), .exp_sum(exp_sum4), .sign(sign4),
        .zero_f(zero4), .inf_f(inf4), .nan_f(nan4),
        .out_valid(out_valid4), .out_ready(out_ready4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                          input logic [47:0] er, input logic [9:0] ee, input logic es,
                          input logic ez, input logic ei, input logic en,
                          input int elat, input int hold);
        int k;
        wait_ready(tag);
        a = oa; b = ob; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        check({tag, " valid_at_T"}, 64'(out_valid), 64'd0);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(elat));
        check({tag, " result_p"}, 64'(result_p), 64'(er));
        check({tag, " exp_sum"}, 64'(exp_sum), 64'(ee));
        check({tag, " flags"}, 64'({sign, zero_f, inf_f, nan_f}), 64'({es, ez, ei, en}));
        check({tag, " busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold"}, 64'({out_valid, in_ready, result_p, exp_sum}),
                  64'({1'b1, 1'b0, er, ee}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " released"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; a = '0; b = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        #12;
        check("reset outputs", 64'({out_valid, sign, zero_f, inf_f, nan_f, exp_sum}), 64'd0);
        check("reset result_p", 64'(result_p), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset ready", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));

        //      tag        a             b             result_p             exp     s  z  i  n  lat hold
        run_op("1.5*1.5", 32'h3FC00000, 32'h3FC00000, 48'h900000000000, 10'h07F, 0, 0, 0, 0, 24, 10);
        run_op("2*-3",    32'h40000000, 32'hC0400000, 48'h600000000000, 10'h081, 1, 0, 0, 0, 24, 0);
        run_op("minnorm", 32'h00800000, 32'h00800000, 48'h400000000000, 10'h383, 0, 0, 0, 0, 24, 0);
        run_op("denorm",  32'h00000001, 32'h3F800000, 48'h000000800000, 10'h001, 0, 0, 0, 0, 24, 0);
        run_op("maxnorm", 32'h7F7FFFFF, 32'h7F7FFFFF, 48'hFFFFFE000001, 10'h17D, 0, 0, 0, 0, 24, 0);
        run_op("zero",    32'h00000000, 32'h3F800000, 48'h0,            10'h000, 0, 1, 0, 0, 1, 0);
        run_op("inf*0",   32'h7F800000, 32'h00000000, 48'h0,            10'h000, 0, 0, 0, 1, 1, 0);
        run_op("inf*1",   32'h7F800000, 32'h3F800000, 48'h0,            10'h000, 0, 0, 1, 0, 1, 3);
        run_op("-0*inf",  32'h80000000, 32'h7F800000, 48'h0,            10'h000, 1, 0, 0, 1, 1, 0);
        run_op("nan*1",   32'h7FC00000, 32'h3F800000, 48'h0,            10'h000, 0, 0, 0, 1, 1, 0);

        // Reset in the middle of a multiply discards the operation.
        wait_ready("abort");
        a = 32'h3FC00000; b = 32'h3FC00000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort outputs", 64'({out_valid, exp_sum, sign}), 64'd0);
        check("abort result_p", 64'(result_p), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("after reset", 32'h40000000, 32'hC0400000, 48'h600000000000, 10'h081, 1, 0, 0, 0, 24, 0);

        // Radix-4 instance retires four multiplier bits per edge.
        k = 0;
        while (!in_ready4 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        a = 32'h3FC00000; b = 32'h3FC00000; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("r4 latency", 64'(k), 64'd6);
        check("r4 result_p", 64'(result_p4), 64'h900000000000);
        check("r4 exp_sum", 64'(exp_sum4), 64'h07F);
        check("r4 flags", 64'({sign4, zero4, inf4, nan4}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
